mips_vn_memory: RTL

MIPS_VN_MEMORY -- requirements
Module: mips_vn_memory

---
 rtl/mips_vn_memory_pkg.sv | 20 ++
 rtl/mips_vn_ram.sv | 27 ++
 rtl/mips_vn_memory.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_vn_memory_pkg.sv
// Shared memory-space definitions for the von Neumann memory block and the CPU:
// MMIO address map, FSM state codes and the illegal-access read pattern.
package mips_vn_memory_pkg;

  localparam logic [31:0] LED_ADDR  = 32'h8000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'h8000_0004;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_READY = 2'b01
  } state_t;

  // Selects the source of the registered read data.
  typedef enum logic {
    RD_VALUE = 1'b0,
    RD_RAM   = 1'b1
  } rd_sel_t;

endpackage

// File: rtl/mips_vn_ram.sv
// Single-port-write, synchronous-read RAM. A read and a write to the same word
// in one cycle return the old word (read-before-write).
module mips_vn_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; the clear sequence
  // in the parent defines its contents after every reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read sample the pre-write word.
    if (en) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/mips_vn_memory.sv
// Von Neumann memory for the MIPS core: RAM, LED register, optional cycle
// counter (MMIO_CYCLE_COUNTER_EN), post-reset clear FSM and sticky fault flag.
module mips_vn_memory
  import mips_vn_memory_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_wr_data,
  input  logic         mem_wr_ena,
  output logic [N-1:0] mem_rd_data,
  output logic [7:0]   leds,
  output logic         busy,
  output logic         fault
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [N-1:0] RAM_BYTES = N'(4 * DEPTH);

  state_t       state_q, state_d;
  logic [AW-1:0] clr_ptr_q;
  rd_sel_t      rd_sel_q, rd_sel_d;
  logic [N-1:0] rd_value_q, rd_value_d;
  logic [7:0]   leds_q;
  logic         fault_q;

  logic         clearing, in_ready;
  logic         aligned, is_ram, is_led, is_cnt, legal;
  logic [N-1:0] cnt_value;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [N-1:0]  ram_wdata;
  logic [N-1:0]  ram_rdata;

  // ---------------- address decode ----------------
  assign aligned = (mem_addr[1:0] == 2'b00);
  assign is_ram  = (mem_addr < RAM_BYTES);
  assign is_led  = (mem_addr == N'(LED_ADDR));
  assign legal   = aligned && (is_ram || is_led || is_cnt);

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt_q <= '0;
    else if (ena && in_ready)   cnt_q <= cnt_q + 32'd1;
  end

  assign is_cnt    = (mem_addr == N'(CNT_ADDR));
  assign cnt_value = N'(cnt_q);
`else
  assign is_cnt    = 1'b0;
  assign cnt_value = '0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state_q <= ST_CLEAR;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = ST_CLEAR;
    case (state_q)
      ST_CLEAR: state_d = (clr_ptr_q == AW'(DEPTH - 1)) ? ST_READY : ST_CLEAR;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    clearing  = (state_q == ST_CLEAR);
    in_ready  = (state_q == ST_READY);
    busy      = !in_ready;
    ram_we    = ena && (clearing || (in_ready && mem_wr_ena && legal && is_ram));
    ram_waddr = clearing ? clr_ptr_q : mem_addr[AW+1:2];
    ram_wdata = clearing ? '0 : mem_wr_data;
  end

  // Pointer wraps to 0 on the last clear write; an illegal state code re-arms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        clr_ptr_q <= '0;
    else if (ena && clearing)        clr_ptr_q <= clr_ptr_q + AW'(1);
    else if (ena && !in_ready)       clr_ptr_q <= '0;
  end

  // ---------------- MMIO and fault ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_q  <= '0;
      fault_q <= 1'b0;
    end else if (ena && in_ready) begin
      if (mem_wr_ena && legal && is_led) leds_q <= mem_wr_data[7:0];
      if (!legal)                        fault_q <= 1'b1;
    end
  end

  assign leds  = leds_q;
  assign fault = fault_q;

  // ---------------- read path ----------------
  always_comb begin
    rd_sel_d   = RD_VALUE;
    rd_value_d = '0;
    if (in_ready) begin
      if (!legal)      rd_value_d = N'(DEAD_BEEF);
      else if (is_ram) rd_sel_d   = RD_RAM;
      else if (is_led) rd_value_d = {{(N-8){1'b0}}, leds_q};
      else             rd_value_d = cnt_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_sel_q   <= RD_VALUE;
      rd_value_q <= '0;
    end else if (ena) begin
      rd_sel_q   <= rd_sel_d;
      rd_value_q <= rd_value_d;
    end
  end

  assign mem_rd_data = (rd_sel_q == RD_RAM) ? ram_rdata : rd_value_q;

  mips_vn_ram #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ena),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mem_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

endmodule
